// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide for the E stage, owning the HI/LO registers.
// state | meaning: IDLE (busy_q=0) takes start/mthi/mtlo; RUN (busy_q=1) counts cnt_q down, writes back at cnt_q==1
module md_unit #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [3:0]  mdu_cal_i,
  input  logic [3:0]  mdu_write_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] OP_SMUL = 4'd1;
  localparam logic [3:0] OP_UMUL = 4'd2;
  localparam logic [3:0] OP_SDIV = 4'd3;
  localparam logic [3:0] OP_UDIV = 4'd4;
  localparam logic [3:0] WR_HI   = 4'd1;
  localparam logic [3:0] WR_LO   = 4'd2;
  localparam logic [3:0] MULT_N  = 4'(MULT_CYC);
  localparam logic [3:0] DIV_N   = 4'(DIV_CYC);

  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] dvd, dvs, quo_u, rem_u, quo, rem;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide runs on magnitudes; this also makes 0x80000000 / -1 wrap cleanly.
  assign a_neg = (op_q == OP_SDIV) & a_q[31];
  assign b_neg = (op_q == OP_SDIV) & b_q[31];
  assign dvd   = a_neg ? (32'd0 - a_q) : a_q;
  assign dvs   = b_neg ? (32'd0 - b_q) : b_q;
  assign quo_u = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
  assign rem_u = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
  assign quo   = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
  assign rem   = a_neg ? (32'd0 - rem_u) : rem_u;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      op_q   <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (!busy_q) begin
      if (start_i) begin
        // A start always drops any concurrent mthi/mtlo, even if the op code is invalid.
        if (mdu_cal_i >= OP_SMUL && mdu_cal_i <= OP_UDIV) begin
          a_d    = a_i;
          b_d    = b_i;
          op_d   = mdu_cal_i;
          cnt_d  = (mdu_cal_i <= OP_UMUL) ? MULT_N : DIV_N;
          busy_d = 1'b1;
        end
      end else if (mdu_write_i == WR_HI) begin
        hi_d = a_i;
      end else if (mdu_write_i == WR_LO) begin
        lo_d = a_i;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        cnt_d  = 4'd0;
        busy_d = 1'b0;
        case (op_q)
          OP_SMUL: {hi_d, lo_d} = prod_s;
          OP_UMUL: {hi_d, lo_d} = prod_u;
          OP_SDIV, OP_UDIV: begin
            if (dvs != 32'd0) begin
              hi_d = rem;
              lo_d = quo;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    busy_o = busy_q;
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO and busy length queued at issue, checked when busy falls.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [3:0]  mdu_cal_i;
  logic [3:0]  mdu_write_i;
  logic [31:0] a_i, b_i;
  logic        busy_o;
  logic [31:0] hi_o, lo_o;

  md_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .mdu_cal_i  (mdu_cal_i),
    .mdu_write_i(mdu_write_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .busy_o     (busy_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
    int          e0;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  logic        busy_prev = 1'b0;
  logic [31:0] m_hi, m_lo;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy_o) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("hi", {32'd0, hi_o}, {32'd0, e.hi});
          chk("lo", {32'd0, lo_o}, {32'd0, e.lo});
          chk("busy_cycles", 64'(cyc - e.e0), 64'(e.n));
        end
      end
      busy_prev = busy_o;
    end
  end

  // Called at a negedge; returns at the negedge after E0 with start released.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int n);
    exp_t e;
    start_i   = 1'b1;
    mdu_cal_i = op;
    a_i       = a;
    b_i       = b;
    @(posedge clk);
    #1;
    e.hi = ehi; e.lo = elo; e.n = n; e.e0 = cyc;
    sb_q.push_back(e);
    m_hi = ehi;
    m_lo = elo;
    @(negedge clk);
    start_i   = 1'b0;
    mdu_cal_i = 4'd0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (busy_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy_o) chk("timeout", 64'd1, 64'd0);
  endtask

  task automatic mtx(input logic [3:0] wr, input logic [31:0] a);
    mdu_write_i = wr;
    a_i         = a;
    @(posedge clk);
    #1;
    if (wr == 4'd1) begin
      m_hi = a;
      chk("mthi", {32'd0, hi_o}, {32'd0, a});
    end else begin
      m_lo = a;
      chk("mtlo", {32'd0, lo_o}, {32'd0, a});
    end
    @(negedge clk);
    mdu_write_i = 4'd0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] p;
    rst_n = 1'b0; start_i = 1'b0; mdu_cal_i = 4'd0; mdu_write_i = 4'd0;
    a_i = 32'd0; b_i = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_hi", {32'd0, hi_o}, 64'd0);
    chk("rst_lo", {32'd0, lo_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(4'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    wait_done();
    @(negedge clk);
    start_op(4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
    wait_done();
    @(negedge clk);
    start_op(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    wait_done();
    @(negedge clk);
    start_op(4'd4, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 10);
    wait_done();
    @(negedge clk);
    start_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    wait_done();
    @(negedge clk);
    start_op(4'd3, 32'd100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 10);
    wait_done();
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i[0]) p = {32'd0, ra} * {32'd0, rb};
      else      p = 64'(longint'(int'(ra)) * longint'(int'(rb)));
      start_op(i[0] ? 4'd2 : 4'd1, ra, rb, p[63:32], p[31:0], 5);
      wait_done();
      @(negedge clk);
    end

    // mthi, then divide by zero with an mtlo attempted while busy
    mtx(4'd1, 32'h12345678);
    mtx(4'd2, 32'h0BADF00D);
    start_op(4'd4, 32'd7, 32'd0, 32'h12345678, m_lo, 10);
    mdu_write_i = 4'd2; a_i = 32'hDEADBEEF; start_i = 1'b1; mdu_cal_i = 4'd1;
    @(negedge clk);
    mdu_write_i = 4'd0; start_i = 1'b0; mdu_cal_i = 4'd0;
    wait_done();
    @(negedge clk);

    // reset in the 4th busy cycle of div 100/7
    start_i = 1'b1; mdu_cal_i = 4'd3; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; mdu_cal_i = 4'd0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {63'd0, busy_o}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy_o}, 64'd0);
    chk("abort_hi", {32'd0, hi_o}, 64'd0);
    chk("abort_lo", {32'd0, lo_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("post_rst_hi", {32'd0, hi_o}, 64'd0);
    chk("post_rst_lo", {32'd0, lo_o}, 64'd0);

    // start with a concurrent mthi: the write must be dropped
    mdu_write_i = 4'd1;
    start_i = 1'b1; mdu_cal_i = 4'd1; a_i = 32'd2; b_i = 32'd3;
    @(posedge clk);
    #1;
    chk("collide_hi", {32'd0, hi_o}, 64'd0);
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd6; e.n = 5; e.e0 = cyc;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start_i = 1'b0; mdu_cal_i = 4'd0; mdu_write_i = 4'd0;
    wait_done();
    start_op(4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5);
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_left", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit of the five-stage MIPS pipeline, sitting in the E stage directly downstream of the instruction decoder. Consumes the decoder's `start`, `MDUcal` and `MDUwrite` controls with the forwarded rs/rt operands. Runs multi-cycle `mult`/`multu`/`div`/`divu` and `mthi`/`mtlo`, and holds the HI/LO registers read by `mfhi`/`mflo`. Drives `busy`; the hazard unit stalls any `md` instruction in D while `start || busy`.

## Interface
- `MULT_CYC`, 5: cycles busy for mult/multu.
- `DIV_CYC`, 10: cycles busy for div/divu.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage instruction is mult/multu/div/divu.
- `MDUcal`  in  4  operation: 0 none, 1 sign_mult, 2 zero_mult, 3 sign_div, 4 zero_div.
- `MDUwrite`  in  4  0 none, 1 whi, 2 wlo.
- `A`  in  32  rs value (forwarded).
- `B`  in  32  rt value (forwarded).
- `busy`  out  1  operation in progress.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.

## Operation
- States: IDLE, RUN. The state is encoded by `busy` plus a 4-bit down-counter `cnt`.
- **IDLE, `start`=1, `MDUcal` in 1..4:**
  - Latch `A`, `B` and `MDUcal` into operand registers.
  - Load `cnt` with `MULT_CYC` for codes 1/2, or `DIV_CYC` for codes 3/4.
  - Set `busy`=1 and go to RUN.
- **IDLE, `start`=1, `MDUcal`=0 or >4:** ignored.
- **IDLE, `start`=0, `MDUwrite`=1:** HI<=A. **`MDUwrite`=2:** LO<=A. Other codes are ignored.
- **RUN:** `cnt` decrements each edge. On the edge where `cnt`==1:
  - Write HI/LO from the latched operands.
  - Set `cnt`=0 and `busy`=0, and return to IDLE.
- **Arithmetic:**
  - sign_mult: {HI,LO} = $signed(A)*$signed(B), full 64 bits.
  - zero_mult: {HI,LO} = unsigned 64-bit product.
  - sign_div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - zero_div: unsigned quotient to LO, remainder to HI.
  - Divide by zero (B==0, either signedness): HI and LO unchanged at completion. Busy timing is the same as a normal divide.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- **Simultaneous and illegal events:**
  - `start` together with nonzero `MDUwrite` in IDLE: `start` wins; the write is dropped.
  - `start` or `MDUwrite` while `busy`: ignored. The hazard unit guarantees this does not occur; the unit must still not corrupt the in-flight operation.
- **Reset (`reset`=0), at any time including mid-RUN:**
  - Immediately HI=0, LO=0, `busy`=0, `cnt`=0; operand registers cleared.
  - The aborted operation produces no writeback.

## Timing
- Reset values: `busy`=0, `HI`=0, `LO`=0.
- Let edge E0 be the edge sampling `start`=1.
  - `busy`=1 from after E0 through the cycle before edge E0+N, where N = `MULT_CYC` or `DIV_CYC`.
  - At E0+N, HI/LO take the result and `busy` falls in the same edge.
  - `busy` is therefore high for exactly N cycles.
- `mfhi`/`mflo` reading HI/LO in the cycle after `busy` falls see the new result.
- An `mthi`/`mtlo` write sampled at edge E is visible on `HI`/`LO` right after E.
- `HI`/`LO` are registered outputs with no combinational bypass from `A`.
- Back-to-back: a new `start` is accepted on the first edge where `busy` was 0 before the edge, i.e. one cycle after completion at the earliest.

## Test plan
- **Signed multiply.** Reset, then `start`, `MDUcal`=1, A=0xFFFFFFFD (-3), B=5.
  - `busy` high for 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **Unsigned multiply.** `MDUcal`=2, A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- **Signed divide.** `MDUcal`=3, A=0xFFFFFFF9 (-7), B=2.
  - `busy` high for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Follow with `MDUcal`=4 on the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- **Divide by zero, then write-while-busy.**
  - `mthi` A=0x12345678 -> HI=0x12345678 next cycle.
  - `divu` 7/0 -> after 10 cycles HI=0x12345678, LO unchanged.
  - During that busy window drive `MDUwrite`=2, A=0xDEADBEEF -> LO unchanged.
- **Reset mid-operation.** Start `div` 100/7; drive `reset`=0 at cycle 4 of busy.
  - `busy`, HI and LO go to 0 immediately.
  - After release, HI and LO stay 0 with no late writeback.
- **Start/write collision and back-to-back.**
  - Assert `start`(`MDUcal`=1, 2*3) with `MDUwrite`=1 -> HI≠A; result HI=0, LO=6.
  - Re-issue `start` on the first idle edge -> accepted, busy 5 more cycles.
